// File: rtl/conv_stream_mac.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : conv_stream_mac
// Purpose  : Streaming causal FIR convolver, one shared MAC, valid/ready I/O.
//            Optional macro CONV_STREAM_SAT_EN: saturate output, add sat_flag.
// Revision : 1.0 - initial release
// ============================================================================
module conv_stream_mac #(
  parameter int DW   = 4,
  parameter int CW   = 4,
  parameter int TAPS = 9,
  parameter int OW   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_data,
  input  logic                     clear_hist,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OW-1:0]            out_data
`ifdef CONV_STREAM_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int KW = $clog2(TAPS);
  localparam int PW = DW + CW;
  localparam int AW = DW + CW + $clog2(TAPS) + 1;
  localparam int MW = (AW > OW) ? AW : OW;
  localparam logic [KW-1:0] KMAX = KW'(TAPS - 1);
  localparam logic [OW-1:0] OMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       hist_q [TAPS];
  logic [DW-1:0]       hist_d [TAPS];
  logic [CW-1:0]       h_q    [TAPS];
  logic [CW-1:0]       h_d    [TAPS];
  logic [AW-1:0]       acc_q, acc_d;
  logic [KW-1:0]       k_q, k_d;
  logic                out_valid_q, out_valid_d;
  logic [OW-1:0]       out_data_q, out_data_d;
  logic [PW-1:0]       prod;
  logic [AW-1:0]       acc_sum;
`ifdef CONV_STREAM_SAT_EN
  logic                sat_q, sat_d;
`endif

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef CONV_STREAM_SAT_EN
  assign sat_flag  = sat_q;
`endif

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    h_d         = h_q;
    acc_d       = acc_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef CONV_STREAM_SAT_EN
    sat_d       = sat_q;
`endif
    prod        = PW'(h_q[k_q]) * PW'(hist_q[k_q]);
    acc_sum     = acc_q + AW'(prod);

    case (state_q)
      S_IDLE: begin
        if (coef_we && (coef_addr <= KMAX)) begin
          h_d[coef_addr] = coef_data;
        end
        if (clear_hist) begin
          for (int i = 0; i < TAPS; i++) hist_d[i] = '0;
        end
        // Clear and shift in the same edge: the new sample lands on an empty history.
        if (in_valid && in_ready) begin
          for (int i = TAPS - 1; i > 0; i--) begin
            hist_d[i] = clear_hist ? '0 : hist_q[i-1];
          end
          hist_d[0] = in_data;
          acc_d     = '0;
          k_d       = '0;
          state_d   = S_MAC;
        end
      end

      S_MAC: begin
        acc_d = acc_sum;
        if (k_q == KMAX) begin
`ifdef CONV_STREAM_SAT_EN
          if (MW'(acc_sum) > MW'(OMAX)) begin
            out_data_d = OMAX;
            sat_d      = 1'b1;
          end else begin
            out_data_d = OW'(acc_sum);
            sat_d      = 1'b0;
          end
`else
          out_data_d = OW'(acc_sum);
`endif
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
`ifdef CONV_STREAM_SAT_EN
          sat_d       = 1'b0;
`endif
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hist_q      <= '{default: '0};
      h_q         <= '{default: '0};
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef CONV_STREAM_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      h_q         <= h_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef CONV_STREAM_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_mac.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_conv_stream_mac
// Purpose  : Scoreboard bench for conv_stream_mac against a direct-sum model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_stream_mac;

  localparam int DW   = 4;
  localparam int CW   = 4;
  localparam int TAPS = 9;
  localparam int OW   = 8;
  localparam int KW   = $clog2(TAPS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          coef_we = 1'b0;
  logic [KW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          clear_hist = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
`ifdef CONV_STREAM_SAT_EN
  logic          sat_flag;
`endif

  conv_stream_mac #(.DW(DW), .CW(CW), .TAPS(TAPS), .OW(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .clear_hist (clear_hist),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef CONV_STREAM_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int s;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   rand_bp = 1'b0;
  exp_t exp_q[$];
  int   lat_q[$];
  int   h_m[TAPS];
  int   hist_m[$];
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT handshake did not occur within bound (t=%0t)", name, $time);
  endtask

  // Direct convolution over the samples seen since the last clear.
  function automatic exp_t model_out();
    exp_t e;
    int   acc = 0;
    for (int k = 0; k < hist_m.size() && k < TAPS; k++) acc += h_m[k] * hist_m[k];
`ifdef CONV_STREAM_SAT_EN
    e.d = (acc > 255) ? 255 : acc;
    e.s = (acc > 255) ? 1 : 0;
`else
    e.d = acc % (1 << OW);
    e.s = 0;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) fail_to("latency_unexpected_rise");
        else chk("latency", cyc, lat_q.pop_front());
      end
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d, no output expected", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), e.d);
`ifdef CONV_STREAM_SAT_EN
          chk("sat_flag", int'(sat_flag), e.s);
`endif
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int x, input bit clr);
    int n  = 0;
    bit ok = 1'b0;
    in_valid   = 1'b1;
    in_data    = DW'(x);
    clear_hist = clr;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      if (clr) hist_m.delete();
      hist_m.push_front(x);
      if (hist_m.size() > TAPS) void'(hist_m.pop_back());
      exp_q.push_back(model_out());
      lat_q.push_back(cyc + 1 + TAPS);
    end else begin
      fail_to("send_accept");
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    clear_hist = 1'b0;
  endtask

  task automatic write_coef(input int a, input int d);
    int n  = 0;
    bit ok = 1'b0;
    coef_we   = 1'b1;
    coef_addr = KW'(a);
    coef_data = CW'(d);
    while (!ok && n < 300) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (ok && a < TAPS) h_m[a] = d;
    if (!ok) fail_to("coef_write");
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic clear_only();
    int n  = 0;
    bit ok = 1'b0;
    clear_hist = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) hist_m.delete();
    else fail_to("clear_hist");
    @(posedge clk);
    #1;
    clear_hist = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    hist_m.delete();
    for (int k = 0; k < TAPS; k++) h_m[k] = 0;
    @(negedge clk);
    chk("in_ready_during_rst", int'(in_ready), 0);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    do_reset();

    // Impulse response
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    clear_only();
    send(1, 1'b0);
    for (int i = 0; i < 9; i++) send(0, 1'b0);
    wait_drain();

    // Overflow / saturation
    for (int k = 0; k < TAPS; k++) write_coef(k, 15);
    send(15, 1'b1);
    send(15, 1'b0);
    wait_drain();

    // Backpressure
    out_ready = 1'b0;
    send(5, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) fail_to("bp_out_valid");
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() > 0) chk("bp_hold_data", int'(out_data), exp_q[0].d);
      chk("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 4'd9;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    wait_drain();

    // Reset at the 4th MAC edge
    send(6, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    send(7, 1'b0);
    wait_drain();

    // Illegal coefficient writes
    do_reset();
    write_coef(0, 2);
    send(1, 1'b0);
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = 4'd9;
    repeat (3) @(posedge clk);
    #1;
    coef_we = 1'b0;
    write_coef(9, 5);
    send(3, 1'b1);
    wait_drain();

    // Clear coinciding with accept
    for (int k = 0; k < TAPS; k++) write_coef(k, 1);
    send(5, 1'b0);
    send(6, 1'b0);
    send(4, 1'b1);
    wait_drain();

    // Randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) write_coef(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      else send(int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #3;
    out_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
`default_nettype wire
